z16_rf_write_arbiter: RTL and testbench
=======================================

Z16_RF_WRITE_ARBITER -- requirements
Module: z16_rf_write_arbiter

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning the register count (fixed; 4-bit addresses).
REQ-002 SHALL have port i_clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_a_valid  input  1  requester A (ALU writeback) write request.
REQ-005 SHALL have port i_a_addr  input  4  requester A destination register.
REQ-006 SHALL have port i_a_data  input  16  requester A write data.
REQ-007 SHALL have port o_a_ready  output  1  requester A accepted this cycle.
REQ-008 SHALL have port i_b_valid / i_b_addr / i_b_data  input  1/4/16  requester B (load writeback), same meaning as A.
REQ-009 SHALL have port o_b_ready  output  1  requester B accepted this cycle.
REQ-010 SHALL have port i_rsv_valid  input  1  reserve a destination register in the scoreboard.
REQ-011 SHALL have port i_rsv_addr  input  4  register to reserve.
REQ-012 SHALL have port i_chk1_addr, i_chk2_addr  input  4 each  hazard-check addresses.
REQ-013 SHALL have port o_chk1_busy, o_chk2_busy  output  1 each  checked register has a pending write.
REQ-014 SHALL have port o_rd_addr / o_rd_wen / o_rd_data  output  4/1/16  register-file write port drive.
REQ-015 SHALL have port o_init_done  output  1  register-file clear sequence complete.

Function
REQ-016 SHALL implement two states, INIT and RUN, plus a 4-bit clear counter cnt.
REQ-017 In INIT, each edge SHALL register o_rd_wen=1, o_rd_addr=cnt, o_rd_data=0 and increment cnt; the edge loading cnt=15 SHALL also set state=RUN and o_init_done=1.
REQ-018 In INIT, o_a_ready and o_b_ready SHALL be 0 and the scoreboard SHALL hold all-zero; i_rsv_valid is ignored.
REQ-019 In RUN, a transfer occurs for X in {A,B} when i_x_valid and o_x_ready are both 1 in the same cycle.
REQ-020 o_x_ready SHALL be combinational: 1 in RUN when X is granted; when one requester is valid, it is granted; when none, no grant.
REQ-021 When both are valid, grant SHALL go to the requester indicated by a 1-bit round-robin pointer; after any transfer the pointer SHALL point to the non-granted requester.
REQ-022 Write latency SHALL be one cycle: a transfer at edge N drives o_rd_wen=1, o_rd_addr, o_rd_data from the granted requester during cycle N+1.
REQ-023 Cycles without a transfer in RUN SHALL drive o_rd_wen=0 (addr/data hold last value).
REQ-024 A transfer to address 0 SHALL complete the handshake but drive o_rd_wen=0.
REQ-025 Scoreboard busy[15:0]: i_rsv_valid with i_rsv_addr!=0 in RUN SHALL set busy[i_rsv_addr] at the edge.
REQ-026 A transfer SHALL clear busy[addr] at the same edge it is registered onto the write port.
REQ-027 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-028 o_chkN_busy SHALL equal busy[i_chkN_addr] combinationally, forced 0 for address 0; no forwarding of the in-flight write.

Reset
REQ-029 While i_rst=1 at an edge: state=INIT, cnt=1, pointer=A, busy=0, o_rd_wen=0, o_rd_addr=0, o_rd_data=0, o_init_done=0.
REQ-030 Reset mid-operation SHALL drop any in-flight write and pending reservations and restart the full clear sequence.
REQ-031 The first cycle with i_rst=0 is cycle 0; clear writes to r1..r15 SHALL appear in cycles 1..15; RUN and o_init_done=1 from cycle 15.

Verification
REQ-032 Reset 2 cycles, release -> o_rd_wen=1 with addr 1..15, data 0 in cycles 1..15; readies 0 in cycles 0..14; o_init_done=1 from cycle 15.
REQ-033 RUN, A only: addr 3, data 0x1234 -> o_a_ready=1 same cycle; next cycle o_rd_wen=1, addr 3, data 0x1234.
REQ-034 Both valid continuously, A addr 2 / B addr 5, from first RUN cycle -> grants A,B,A,B; write port shows 2,5,2,5.
REQ-035 rsv addr 7 -> o_chk1_busy (addr 7)=1 next cycle; B transfer addr 7 -> 0 next cycle; rsv 7 with transfer 7 in the same cycle -> stays 1.
REQ-036 A transfer addr 0 -> o_a_ready=1, next cycle o_rd_wen=0; rsv addr 0 -> o_chk busy for 0 stays 0.
REQ-037 i_rst in RUN with busy[4]=1 and a transfer this cycle -> next cycle o_rd_wen=0, busy all 0, o_init_done=0; clear sequence repeats.

Source files
------------

// File: rtl/z16_rf_write_arbiter.sv
// z16_rf_write_arbiter
// Two-requester register-file write arbiter with a power-on clear sequence
// and a pending-write scoreboard for hazard checks.
//
// After reset the block walks r1..r15 writing zero (INIT), then enters RUN.
// In RUN, requesters A (ALU) and B (load) compete for the single write port.
// A lone valid requester is granted. When both are valid, a round-robin
// pointer picks the winner. The accepted write is registered onto the port
// one cycle later. Writes to r0 complete the handshake but never assert the
// write enable.
//
// The scoreboard marks registers that have an outstanding write. A
// reservation sets the bit, and the matching writeback clears it. If both
// happen on the same edge, the reservation wins because it belongs to a
// newer instruction.
module z16_rf_write_arbiter #(
    parameter int NREG = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic [3:0]  i_a_addr,
    input  logic [15:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [3:0]  i_b_addr,
    input  logic [15:0] i_b_data,
    output logic        o_b_ready,
    input  logic        i_rsv_valid,
    input  logic [3:0]  i_rsv_addr,
    input  logic [3:0]  i_chk1_addr,
    input  logic [3:0]  i_chk2_addr,
    output logic        o_chk1_busy,
    output logic        o_chk2_busy,
    output logic [3:0]  o_rd_addr,
    output logic        o_rd_wen,
    output logic [15:0] o_rd_data,
    output logic        o_init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              ptr_r;       // 0: A wins a tie, 1: B wins a tie
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              xfer_s;
    logic [3:0]        xfer_addr_s;
    logic [15:0]       xfer_data_s;

    // Next state and clear counter: INIT walks cnt up to 15, then RUN is terminal until reset.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == 4'd15) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Grant selection: a lone requester wins, and a tie goes to the round-robin pointer.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (i_a_valid && i_b_valid) begin
                if (ptr_r) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end else begin
                grant_a_s = i_a_valid;
                grant_b_s = i_b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign xfer_s      = grant_a_s | grant_b_s;
    assign xfer_addr_s = grant_b_s ? i_b_addr : i_a_addr;
    assign xfer_data_s = grant_b_s ? i_b_data : i_a_data;
    assign o_a_ready   = grant_a_s;
    assign o_b_ready   = grant_b_s;

    // Scoreboard update: clear on writeback first, then apply the reservation so that a same-edge set wins.
    always_comb begin
        busy_s = busy_r;
        if (state_r == ST_RUN) begin
            if (xfer_s) begin
                busy_s[xfer_addr_s] = 1'b0;
            end else begin
                busy_s = busy_s;
            end
            if (i_rsv_valid && (i_rsv_addr != 4'd0)) begin
                busy_s[i_rsv_addr] = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end else begin
            busy_s = {NREG{1'b0}};
        end
    end

    // Hazard checks read the registered scoreboard directly, with no forwarding; r0 is never busy.
    assign o_chk1_busy = (i_chk1_addr != 4'd0) && busy_r[i_chk1_addr];
    assign o_chk2_busy = (i_chk2_addr != 4'd0) && busy_r[i_chk2_addr];

    // Control state: FSM, clear counter, arbitration pointer and scoreboard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_INIT;
            cnt_r   <= 4'd1;
            ptr_r   <= 1'b0;
            busy_r  <= {NREG{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            if (xfer_s) begin
                ptr_r <= grant_a_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Register-file write port: clear writes during INIT, granted writebacks one cycle after acceptance in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_wen    <= 1'b0;
            o_rd_addr   <= 4'd0;
            o_rd_data   <= 16'd0;
            o_init_done <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    o_rd_wen    <= 1'b1;
                    o_rd_addr   <= cnt_r;
                    o_rd_data   <= 16'd0;
                    o_init_done <= (cnt_r == 4'd15);
                end
                ST_RUN: begin
                    o_init_done <= 1'b1;
                    o_rd_wen    <= xfer_s && (xfer_addr_s != 4'd0);
                    if (xfer_s) begin
                        o_rd_addr <= xfer_addr_s;
                        o_rd_data <= xfer_data_s;
                    end else begin
                        o_rd_addr <= o_rd_addr;
                        o_rd_data <= o_rd_data;
                    end
                end
                default: begin
                    o_rd_wen    <= 1'b0;
                    o_rd_addr   <= o_rd_addr;
                    o_rd_data   <= o_rd_data;
                    o_init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z16_rf_write_arbiter.sv
// Self-checking bench for z16_rf_write_arbiter.
// A cycle-indexed behavioural model predicts the outputs on every cycle.
// Directed sequences with literal expectations pin the model for the
// clear sequence, latency, round-robin order, the scoreboard and reset.
// A randomized phase then exercises arbitration, reservations and reset.
module tb_z16_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [3:0]  a_addr = 4'd0;
    logic [15:0] a_data = 16'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [3:0]  b_addr = 4'd0;
    logic [15:0] b_data = 16'd0;
    logic        b_ready;
    logic        rsv_valid = 1'b0;
    logic [3:0]  rsv_addr = 4'd0;
    logic [3:0]  chk1_addr = 4'd0;
    logic [3:0]  chk2_addr = 4'd0;
    logic        chk1_busy;
    logic        chk2_busy;
    logic [3:0]  rd_addr;
    logic        rd_wen;
    logic [15:0] rd_data;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    // Model state. m_cyc counts cycles since the last reset edge; the block is in RUN once m_cyc >= 15.
    bit          m_known = 1'b0;
    int          m_cyc = 0;
    bit          m_ptr_b = 1'b0;
    bit          m_busy [16];
    bit          m_wen = 1'b0;
    logic [3:0]  m_addr = 4'd0;
    logic [15:0] m_data = 16'd0;
    bit          m_done = 1'b0;

    z16_rf_write_arbiter #(.NREG(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a_valid   (a_valid),
        .i_a_addr    (a_addr),
        .i_a_data    (a_data),
        .o_a_ready   (a_ready),
        .i_b_valid   (b_valid),
        .i_b_addr    (b_addr),
        .i_b_data    (b_data),
        .o_b_ready   (b_ready),
        .i_rsv_valid (rsv_valid),
        .i_rsv_addr  (rsv_addr),
        .i_chk1_addr (chk1_addr),
        .i_chk2_addr (chk2_addr),
        .o_chk1_busy (chk1_busy),
        .o_chk2_busy (chk2_busy),
        .o_rd_addr   (rd_addr),
        .o_rd_wen    (rd_wen),
        .o_rd_data   (rd_data),
        .o_init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare the DUT to the model, predict the edge, and advance past it.
    task automatic tick();
        bit         run;
        bit         ga;
        bit         gb;
        logic [3:0] ta;
        logic [15:0] td;
        #1;
        run = (m_cyc >= 15);
        ga  = run && a_valid && (!b_valid || !m_ptr_b);
        gb  = run && b_valid && !ga;
        if (m_known) begin
            chk("mdl_a_ready", {31'd0, a_ready}, {31'd0, ga});
            chk("mdl_b_ready", {31'd0, b_ready}, {31'd0, gb});
            chk("mdl_chk1", {31'd0, chk1_busy}, {31'd0, (chk1_addr != 4'd0) && m_busy[chk1_addr]});
            chk("mdl_chk2", {31'd0, chk2_busy}, {31'd0, (chk2_addr != 4'd0) && m_busy[chk2_addr]});
            chk("mdl_wen", {31'd0, rd_wen}, {31'd0, m_wen});
            chk("mdl_done", {31'd0, init_done}, {31'd0, m_done});
            if (m_wen) begin
                chk("mdl_addr", {28'd0, rd_addr}, {28'd0, m_addr});
                chk("mdl_data", {16'd0, rd_data}, {16'd0, m_data});
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_known = 1'b1;
            m_cyc   = 0;
            m_ptr_b = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_wen   = 1'b0;
            m_addr  = 4'd0;
            m_data  = 16'd0;
            m_done  = 1'b0;
        end else if (!run) begin
            m_wen  = 1'b1;
            m_addr = 4'(m_cyc + 1);
            m_data = 16'd0;
            m_done = (m_cyc + 1 == 15);
            m_cyc  = m_cyc + 1;
        end else begin
            m_done = 1'b1;
            if (ga || gb) begin
                ta = ga ? a_addr : b_addr;
                td = ga ? a_data : b_data;
                m_wen   = (ta != 4'd0);
                m_addr  = ta;
                m_data  = td;
                m_ptr_b = ga;
                m_busy[ta] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            if (rsv_valid && rsv_addr != 4'd0) m_busy[rsv_addr] = 1'b1;
            if (m_cyc < 1000) m_cyc = m_cyc + 1;
        end
    endtask

    task automatic idle_inputs();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        rsv_valid = 1'b0;
    endtask

    initial begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        @(posedge clk);
        #1;

        // Clear sequence and the first write latency, with A requesting throughout.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            a_valid = (c <= 15);
            a_addr  = 4'd3;
            a_data  = 16'h1234;
            #1;
            if (c <= 14) chk("init_a_ready", {31'd0, a_ready}, 32'd0);
            if (c >= 1 && c <= 15) begin
                chk("init_wen", {31'd0, rd_wen}, 32'd1);
                chk("init_addr", {28'd0, rd_addr}, c);
                chk("init_data", {16'd0, rd_data}, 32'd0);
            end
            if (c <= 16) chk("init_done", {31'd0, init_done}, (c >= 15) ? 32'd1 : 32'd0);
            if (c == 15) chk("a_only_ready", {31'd0, a_ready}, 32'd1);
            if (c == 16) begin
                chk("a_only_wen", {31'd0, rd_wen}, 32'd1);
                chk("a_only_addr", {28'd0, rd_addr}, 32'd3);
                chk("a_only_data", {16'd0, rd_data}, 32'h1234);
            end
            if (c == 17) chk("idle_wen", {31'd0, rd_wen}, 32'd0);
            tick();
        end

        // Scoreboard set, clear by B writeback, and set winning over a same-edge clear.
        idle_inputs();
        rsv_valid = 1'b1;
        rsv_addr  = 4'd7;
        chk1_addr = 4'd7;
        tick();
        rsv_valid = 1'b0;
        b_valid   = 1'b1;
        b_addr    = 4'd7;
        b_data    = 16'hbeef;
        #1;
        chk("rsv_set", {31'd0, chk1_busy}, 32'd1);
        chk("b_only_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("rsv_clear", {31'd0, chk1_busy}, 32'd0);
        chk("b_wr_addr", {28'd0, rd_addr}, 32'd7);
        chk("b_wr_data", {16'd0, rd_data}, 32'hbeef);
        rsv_valid = 1'b1;
        tick();
        b_valid = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("set_wins", {31'd0, chk1_busy}, 32'd1);

        // Write to r0 completes the handshake but does not write; r0 can never be reserved.
        a_valid = 1'b1;
        a_addr  = 4'd0;
        #1;
        chk("r0_ready", {31'd0, a_ready}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("r0_no_wen", {31'd0, rd_wen}, 32'd0);
        rsv_valid = 1'b1;
        rsv_addr  = 4'd0;
        chk2_addr = 4'd0;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("r0_never_busy", {31'd0, chk2_busy}, 32'd0);
        tick();

        // Reset in RUN with a reservation pending and a transfer in flight.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd4;
        chk1_addr = 4'd4;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("rsv4_set", {31'd0, chk1_busy}, 32'd1);
        rst     = 1'b1;
        a_valid = 1'b1;
        a_addr  = 4'd9;
        a_data  = 16'h5555;
        tick();
        rst     = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("rst_wen", {31'd0, rd_wen}, 32'd0);
        chk("rst_busy", {31'd0, chk1_busy}, 32'd0);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        for (int c = 0; c < 15; c++) tick();

        // Both requesters valid from the first RUN cycle: grants alternate A, B, A, B.
        for (int k = 0; k <= 4; k++) begin
            a_valid = (k < 4);
            b_valid = (k < 4);
            a_addr  = 4'd2;
            b_addr  = 4'd5;
            a_data  = 16'h00a2;
            b_data  = 16'h00b5;
            #1;
            if (k < 4) begin
                chk("rr_a_ready", {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("rr_b_ready", {31'd0, b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (k >= 1) begin
                chk("rr_wen", {31'd0, rd_wen}, 32'd1);
                chk("rr_addr", {28'd0, rd_addr}, ((k - 1) % 2 == 0) ? 32'd2 : 32'd5);
            end
            tick();
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 149) == 0);
            a_valid   = $urandom_range(0, 1);
            b_valid   = $urandom_range(0, 1);
            a_addr    = 4'($urandom_range(0, 7));
            b_addr    = 4'($urandom_range(0, 7));
            a_data    = 16'($urandom);
            b_data    = 16'($urandom);
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = 4'($urandom_range(0, 7));
            chk1_addr = 4'($urandom_range(0, 7));
            chk2_addr = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
